// File: rtl/ps2_key_tracker_pkg.sv
// ps2_key_tracker_pkg: PS/2 set-2 prefix codes, pause tail length and tracker state encoding
package ps2_key_tracker_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_PAUSE   = 8'hE1;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return b == SC_EXT || b == SC_BRK || b == SC_PAUSE;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_code_match.sv
// ps2_key_tracker_code_match: compares a completed code and its E0 flag against every bound key
module ps2_key_tracker_code_match #(
    parameter int                     NUM_KEYS  = 3,
    parameter logic [8*NUM_KEYS-1:0]  KEY_CODES = {8'h74, 8'h6B, 8'h75},
    parameter logic [NUM_KEYS-1:0]    KEY_EXT   = '1
) (
    input  logic [7:0]          code,
    input  logic                ext,
    output logic [NUM_KEYS-1:0] hit
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        assign hit[i] = code == KEY_CODES[8*i +: 8] && ext == KEY_EXT[i];
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns the PS/2 set-2 byte stream into held flags and press/release pulses per bound key
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                     NUM_KEYS       = 3,
    parameter logic [8*NUM_KEYS-1:0]  KEY_CODES      = {8'h74, 8'h6B, 8'h75},
    parameter logic [NUM_KEYS-1:0]    KEY_EXT        = '1,
    parameter int                     TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [7:0]          last_code,
    output logic                last_ext,
    output logic                last_break,
    output logic                seq_error
);

    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                state, state_n;
    logic [2:0]            skip, skip_n;
    logic [TW-1:0]         tcnt;
    logic                  done, brk, ext, err, expired;
    logic [NUM_KEYS-1:0]   hit;

    assign expired = state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1);

    ps2_key_tracker_code_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES),
        .KEY_EXT   (KEY_EXT)
    ) u_match (
        .code (received_data),
        .ext  (ext),
        .hit  (hit)
    );

    always_comb begin
        state_n = state;
        skip_n  = skip;
        done    = 1'b0;
        brk     = 1'b0;
        ext     = 1'b0;
        err     = 1'b0;
        if (received_data_en) begin
            case (state)
                IDLE: begin
                    state_n = received_data == SC_EXT   ? EXT  :
                              received_data == SC_BRK   ? BRK  :
                              received_data == SC_PAUSE ? SKIP : IDLE;
                    skip_n  = received_data == SC_PAUSE ? PAUSE_TAIL : skip;
                    done    = !is_prefix(received_data);
                end
                EXT: begin
                    state_n = received_data == SC_BRK ? EXT_BRK : IDLE;
                    err     = received_data == SC_EXT || received_data == SC_PAUSE;
                    done    = !is_prefix(received_data);
                    ext     = 1'b1;
                end
                BRK, EXT_BRK: begin
                    state_n = IDLE;
                    err     = is_prefix(received_data);
                    done    = !is_prefix(received_data);
                    brk     = 1'b1;
                    ext     = state == EXT_BRK;
                end
                SKIP: begin
                    skip_n  = skip - 3'd1;
                    state_n = skip == 3'd1 ? IDLE : SKIP;
                end
                default: state_n = IDLE;
            endcase
        end else if (expired) begin
            state_n = IDLE;
            err     = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            skip        <= '0;
            tcnt        <= '0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            last_code   <= '0;
            last_ext    <= 1'b0;
            last_break  <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state       <= state_n;
            skip        <= skip_n;
            tcnt        <= (received_data_en || state_n == IDLE) ? '0 : tcnt + 1'b1;
            // repeats of a held make and breaks of an idle key leave held untouched and pulse nothing
            key_held    <= done ? (brk ? key_held & ~hit : key_held | hit) : key_held;
            key_press   <= (done && !brk) ? hit & ~key_held : '0;
            key_release <= (done && brk) ? hit & key_held : '0;
            seq_error   <= err;
            if (done) begin
                last_code  <= received_data;
                last_ext   <= ext;
                last_break <= brk;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed scenarios plus random byte streams checked against a prefix-queue model
module tb_ps2_key_tracker;

    localparam int T = 100;
    localparam logic [7:0] KC [3] = '{8'h75, 8'h6B, 8'h74};
    localparam logic [7:0] POOL [9] = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h6B, 8'h74, 8'h1C, 8'hFA, 8'hAA};

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [7:0] received_data;
    logic       received_data_en;
    logic [2:0] key_held, key_press, key_release;
    logic [7:0] last_code;
    logic       last_ext, last_break, seq_error;

    int total = 0;
    int bad = 0;

    logic [2:0] m_held, m_press, m_rel;
    logic [7:0] m_code;
    logic       m_ext, m_brk, m_err;
    logic [7:0] pq[$];
    int         skip_left;
    longint     cyc = 0;
    longint     last_s = 0;

    ps2_key_tracker #(
        .NUM_KEYS       (3),
        .KEY_CODES      ({8'h74, 8'h6B, 8'h75}),
        .KEY_EXT        (3'b111),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .resetn           (resetn),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .key_held         (key_held),
        .key_press        (key_press),
        .key_release      (key_release),
        .last_code        (last_code),
        .last_ext         (last_ext),
        .last_break       (last_break),
        .seq_error        (seq_error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic m_reset();
        m_held = '0; m_press = '0; m_rel = '0; m_code = '0;
        m_ext = 1'b0; m_brk = 1'b0; m_err = 1'b0;
        pq.delete();
        skip_left = 0;
    endtask

    task automatic m_complete(input logic [7:0] b, input logic e, input logic k);
        for (int i = 0; i < 3; i++) begin
            if (b == KC[i] && e) begin
                if (!k && !m_held[i]) begin m_held[i] = 1'b1; m_press[i] = 1'b1; end
                if (k && m_held[i]) begin m_held[i] = 1'b0; m_rel[i] = 1'b1; end
            end
        end
        m_code = b; m_ext = e; m_brk = k;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic pre, has_brk;
        pre = b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
        if (skip_left > 0) skip_left--;
        else if (pq.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pq.push_back(b);
            else if (b == 8'hE1) skip_left = 7;
            else m_complete(b, 1'b0, 1'b0);
        end else begin
            has_brk = pq[pq.size()-1] == 8'hF0;
            if (pre && !has_brk && b == 8'hF0) pq.push_back(b);
            else if (pre) begin m_err = 1'b1; pq.delete(); end
            else begin m_complete(b, pq[0] == 8'hE0, has_brk); pq.delete(); end
        end
    endtask

    always @(negedge resetn) m_reset();

    always @(posedge CLOCK_50) begin
        cyc++;
        m_press = '0; m_rel = '0; m_err = 1'b0;
        if (!resetn) m_reset();
        else if (received_data_en) begin
            last_s = cyc;
            m_byte(received_data);
        end else if ((pq.size() > 0 || skip_left > 0) && cyc - last_s == T) begin
            m_err = 1'b1;
            pq.delete();
            skip_left = 0;
        end
        #1;
        chk("held", {5'd0, key_held}, {5'd0, m_held});
        chk("press", {5'd0, key_press}, {5'd0, m_press});
        chk("release", {5'd0, key_release}, {5'd0, m_rel});
        chk("last_code", last_code, m_code);
        chk("last_flags", {6'd0, last_ext, last_break}, {6'd0, m_ext, m_brk});
        chk("seq_error", {7'd0, seq_error}, {7'd0, m_err});
    end

    task automatic step(input logic en, input logic [7:0] d);
        @(negedge CLOCK_50);
        received_data_en = en;
        received_data = d;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic settle();
        @(posedge CLOCK_50);
        #2;
    endtask

    initial begin
        int errs;
        resetn = 1'b0;
        received_data_en = 1'b0;
        received_data = '0;
        repeat (2) @(negedge CLOCK_50);
        chk("rst_held", {5'd0, key_held}, 8'h00);
        chk("rst_last", last_code, 8'h00);
        resetn = 1'b1;
        send(8'hE0); send(8'h75); settle();
        chk("s1_held", {5'd0, key_held}, 8'h01);
        chk("s1_press", {5'd0, key_press}, 8'h01);
        step(1'b0, 8'h00); settle();
        chk("s1_press_end", {5'd0, key_press}, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h75); settle();
        chk("s1_rel_held", {5'd0, key_held}, 8'h00);
        chk("s1_release", {5'd0, key_release}, 8'h01);
        send(8'hE0); send(8'h6B); settle();
        chk("s2_press", {5'd0, key_press}, 8'h02);
        repeat (3) begin send(8'hE0); send(8'h6B); end
        settle();
        chk("s2_typematic", {5'd0, key_press}, 8'h00);
        chk("s2_held", {5'd0, key_held}, 8'h02);
        send(8'hE0); send(8'hF0); send(8'h6B); settle();
        chk("s2_cleared", {5'd0, key_held}, 8'h00);
        send(8'h1C); settle();
        chk("s3_code", last_code, 8'h1C);
        chk("s3_brk0", {7'd0, last_break}, 8'h00);
        send(8'hF0); send(8'h1C); settle();
        chk("s3_brk1", {7'd0, last_break}, 8'h01);
        send(8'h75); settle();
        chk("s3_plain", {5'd0, key_held}, 8'h00);
        chk("s3_ext", {7'd0, last_ext}, 8'h00);
        errs = 0;
        send(8'hE0);
        for (int i = 0; i < 110; i++) begin step(1'b0, 8'h00); settle(); errs += int'(seq_error); end
        chk("s4_timeout_pulses", 8'(errs), 8'd1);
        errs = 0;
        send(8'hE0);
        for (int i = 0; i < 99; i++) begin step(1'b0, 8'h00); settle(); errs += int'(seq_error); end
        send(8'h75); settle(); errs += int'(seq_error);
        step(1'b0, 8'h00); settle(); errs += int'(seq_error);
        chk("s4_expiry_no_err", 8'(errs), 8'd0);
        chk("s4_expiry_held", {5'd0, key_held}, 8'h01);
        send(8'hE0); send(8'hF0); send(8'h75);
        foreach (POOL[i]) if (i < 0) $display("unused");
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); settle();
        chk("s5_pause_code", last_code, 8'h75);
        chk("s5_pause_held", {5'd0, key_held}, 8'h00);
        send(8'hE0); send(8'h74); settle();
        chk("s5_held", {5'd0, key_held}, 8'h04);
        send(8'hE0); send(8'h75); send(8'hE0); settle();
        resetn = 1'b0;
        #1;
        chk("s6_held", {5'd0, key_held}, 8'h00);
        chk("s6_code", last_code, 8'h00);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        received_data_en = 1'b0;
        send(8'hF0); send(8'h75); settle();
        chk("s6_no_release", {5'd0, key_release}, 8'h00);
        chk("s6_flags", {6'd0, last_ext, last_break}, 8'h01);
        for (int n = 0; n < 2500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) repeat ($urandom_range(95, 105)) step(1'b0, 8'h00);
            else if (r == 99) begin
                @(negedge CLOCK_50); resetn = 1'b0; received_data_en = 1'b0;
                @(negedge CLOCK_50); resetn = 1'b1;
            end
            else if (r < 55) send(POOL[$urandom_range(0, 8)]);
            else step(1'b0, 8'h00);
        end
        step(1'b0, 8'h00);
        repeat (3) @(negedge CLOCK_50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
